uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encoding, used by both uart_rx and uart_tx
// so that the two ends agree on a single baud constant.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
  localparam int unsigned MID_DEFAULT          = CLKS_PER_BIT_DEFAULT / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // 2-of-3 majority vote used to filter single-sample glitches
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into sys_clk with a 2-FF synchronizer
// and flags a high-to-low transition using a third delay FF.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic r_meta;
  logic r_s;
  logic r_d;

  // Idle-high reset so a line held high after reset is not seen as an edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_meta <= 1'b1;
      r_s    <= 1'b1;
      r_d    <= 1'b1;
    end else begin
      r_meta <= rx_in;
      r_s    <= r_meta;
      r_d    <= r_s;
    end
  end

  assign rx_s = r_s;
  assign fall = r_d & ~r_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-of-bit majority sampling, LSB-first shifter,
// and early return to IDLE at stop-bit centre for gapless back-to-back frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned MID          = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic             w_rx_s;
  logic             w_fall;
  logic             w_wrap;
  logic             w_resolve;
  logic             w_bit;

  rx_state_e        r_state;
  rx_state_e        w_state_next;
  logic [CNT_W-1:0] r_baud;
  logic [CNT_W-1:0] w_baud_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic [7:0]       r_data;
  logic [7:0]       w_data_next;
  logic             w_done_next;
  logic             w_err_next;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic             r_samp0;
  logic             r_samp1;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_in     (rx_in),
    .rx_s      (w_rx_s),
    .fall      (w_fall)
  );

  assign w_wrap    = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_resolve = (r_baud == CNT_W'(MID + 1));
  assign w_bit     = maj3(r_samp0, r_samp1, w_rx_s);

  // Next-state, counters, shifter and pulse decode
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = w_wrap ? '0 : r_baud + CNT_W'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_next    = '0;
        w_bit_idx_next = 3'd0;
        if (w_fall) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_resolve && w_bit) begin
          w_state_next = ST_IDLE;
          w_baud_next  = '0;
        end else if (w_wrap) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_resolve) begin
          w_shift_next[r_bit_idx] = w_bit;
        end
        if (w_wrap) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Leave at stop-bit centre so a following start edge is not missed
        if (w_resolve) begin
          w_state_next = ST_IDLE;
          w_baud_next  = '0;
          if (w_bit) begin
            w_data_next = r_shift;
            w_done_next = 1'b1;
          end else begin
            w_err_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_baud_next  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_samp0   <= 1'b1;
      r_samp1   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_busy    <= (w_state_next != ST_IDLE);
      if (r_baud == CNT_W'(MID - 1)) begin
        r_samp0 <= w_rx_s;
      end
      if (r_baud == CNT_W'(MID)) begin
        r_samp1 <= w_rx_s;
      end
    end
  end

  assign data      = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_err;
  assign rx_busy   = r_busy;

endmodule
